multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared datapath: register file, ALU, immediate generator and PC register. It decodes `inst[6:0]` and drives every enable and mux select, so one instruction completes every 3–5 cycles, plus memory wait states. It also flags illegal opcodes and emits a one-cycle retire pulse per instruction.

---
 rtl/rv32_pkg.sv | 58 +++++
 rtl/ctrl_opclass.sv | 32 +++
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared encodings for the RV32I multi-cycle control path
package rv32_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      S_BOOT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   // Major opcodes, inst[6:2]; shared with the immediate generator
   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   // Next-PC source select
   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_ALU   = 2'b01;
   localparam logic [1:0] PC_JALR  = 2'b10;

   // ALU operation select
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_FUNCT  = 2'b01;
   localparam logic [1:0] ALU_PASS_B = 2'b10;

   // Register file write-back source select
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // One-hot instruction class produced by ctrl_opclass
   typedef struct packed {
      logic alu_r;
      logic alu_i;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic jalr;
      logic lui;
      logic auipc;
      logic nop;
      logic illegal;
   } opclass_t;

endpackage

// File: rtl/ctrl_opclass.sv
// rtl/ctrl_opclass.sv - opcode field to one-hot instruction class
import rv32_pkg::*;

module ctrl_opclass (
   input  logic [6:0] opcode,
   output opclass_t   cls
);

   // Anything without the 32-bit length marker or with an unlisted opcode is illegal
   always_comb begin
      cls = '0;
      if (opcode[1:0] != 2'b11) begin
         cls.illegal = 1'b1;
      end else begin
         case (opcode[6:2])
            OPC_OP:       cls.alu_r   = 1'b1;
            OPC_OP_IMM:   cls.alu_i   = 1'b1;
            OPC_LOAD:     cls.load    = 1'b1;
            OPC_STORE:    cls.store   = 1'b1;
            OPC_BRANCH:   cls.branch  = 1'b1;
            OPC_JAL:      cls.jal     = 1'b1;
            OPC_JALR:     cls.jalr    = 1'b1;
            OPC_LUI:      cls.lui     = 1'b1;
            OPC_AUIPC:    cls.auipc   = 1'b1;
            OPC_MISC_MEM: cls.nop     = 1'b1;
            OPC_SYSTEM:   cls.nop     = 1'b1;
            default:      cls.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM
import rv32_pkg::*;

module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic        ir_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_isel,
   output logic        reg_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [1:0]  alu_op,
   output logic [1:0]  wb_sel,
   output logic        retire,
   output logic        illegal
);

   state_t   state;
   state_t   state_nx;
   opclass_t cls;

   // Only the opcode field steers control; the rest of inst feeds the datapath
   logic unused_inst;
   assign unused_inst = ^inst[31:7];

   ctrl_opclass u_opclass (
      .opcode (inst[6:0]),
      .cls    (cls)
   );

   // State register; reset lands in BOOT, where every output is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_BOOT;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and Moore outputs, with mem_ready/br_taken qualifying only the handshake terms
   always_comb begin
      state_nx  = state;
      ir_we     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_isel  = 1'b0;
      reg_we    = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = ALU_ADD;
      wb_sel    = WB_ALU;
      retire    = 1'b0;
      illegal   = 1'b0;

      // ALU operand/op selection is held through MEM so the address stays valid
      if (state == S_EXEC || state == S_MEM) begin
         alu_a_sel = cls.branch | cls.jal | cls.auipc;
         alu_b_sel = cls.alu_i | cls.load | cls.store | cls.branch |
                     cls.jal | cls.jalr | cls.lui | cls.auipc;
         if (cls.alu_r || cls.alu_i) begin
            alu_op = ALU_FUNCT;
         end else if (cls.lui) begin
            alu_op = ALU_PASS_B;
         end
      end

      case (state)
         S_BOOT: begin
            state_nx = S_FETCH;
         end
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_isel = 1'b1;
            if (mem_ready) begin
               ir_we    = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            state_nx = cls.illegal ? S_TRAP : S_EXEC;
         end
         S_EXEC: begin
            if (cls.branch) begin
               pc_we    = 1'b1;
               pc_sel   = br_taken ? PC_ALU : PC_PLUS4;
               retire   = 1'b1;
               state_nx = S_FETCH;
            end else if (cls.nop) begin
               pc_we    = 1'b1;
               retire   = 1'b1;
               state_nx = S_FETCH;
            end else if (cls.load || cls.store) begin
               state_nx = S_MEM;
            end else if (cls.illegal) begin
               state_nx = S_TRAP;
            end else begin
               state_nx = S_WB;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = cls.store;
            if (mem_ready) begin
               if (cls.store) begin
                  pc_we    = 1'b1;
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end else begin
                  state_nx = S_WB;
               end
            end
         end
         S_WB: begin
            reg_we   = 1'b1;
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = S_FETCH;
            if (cls.load) begin
               wb_sel = WB_MEM;
            end else if (cls.jal || cls.jalr) begin
               wb_sel = WB_PC4;
            end
            if (cls.jal) begin
               pc_sel = PC_ALU;
            end else if (cls.jalr) begin
               pc_sel = PC_JALR;
            end
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            state_nx = S_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        mem_ready;
   logic        br_taken;
   logic        ir_we, mem_req, mem_we, mem_isel, reg_we, pc_we;
   logic [1:0]  pc_sel;
   logic        alu_a_sel, alu_b_sel;
   logic [1:0]  alu_op;
   logic [1:0]  wb_sel;
   logic        retire, illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inst      (inst),
      .mem_ready (mem_ready),
      .br_taken  (br_taken),
      .ir_we     (ir_we),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_isel  (mem_isel),
      .reg_we    (reg_we),
      .pc_we     (pc_we),
      .pc_sel    (pc_sel),
      .alu_a_sel (alu_a_sel),
      .alu_b_sel (alu_b_sel),
      .alu_op    (alu_op),
      .wb_sel    (wb_sel),
      .retire    (retire),
      .illegal   (illegal)
   );

   // {ir_we,mem_req,mem_we,mem_isel}_{reg_we,pc_we,pc_sel}_{a_sel,b_sel,alu_op}_{wb_sel,retire,illegal}
   logic [15:0] act;
   assign act = {ir_we, mem_req, mem_we, mem_isel, reg_we, pc_we, pc_sel,
                 alu_a_sel, alu_b_sel, alu_op, wb_sel, retire, illegal};

   localparam logic [15:0] O_ZERO  = 16'b0000_0000_0000_0000;
   localparam logic [15:0] O_FETCH = 16'b1101_0000_0000_0000;
   localparam logic [15:0] O_FWAIT = 16'b0101_0000_0000_0000;
   localparam logic [15:0] O_WBALU = 16'b0000_1100_0000_0010;
   localparam logic [15:0] O_AGEN  = 16'b0000_0000_0100_0000;
   localparam logic [15:0] O_LDMEM = 16'b0100_0000_0100_0000;
   localparam logic [15:0] O_TRAP  = 16'b0000_0000_0000_0001;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_BEQ   = 32'h00000063;
   localparam logic [31:0] I_JALR  = 32'h000080E7;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_LUI   = 32'h000012B7;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_AUIPC = 32'h00000097;
   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_FENCE = 32'h0000000F;
   localparam logic [31:0] I_BAD   = 32'h00000000;

   typedef struct {
      logic [31:0] inst;
      logic        rdy;
      logic        bt;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [31:0] i, logic r, logic b, logic [15:0] e, string n);
      vec_t v;
      v.inst = i;
      v.rdy  = r;
      v.bt   = b;
      v.exp  = e;
      v.name = n;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // One controller cycle: drive after the edge, compare at the falling edge
   task automatic step(input vec_t v);
      inst      = v.inst;
      mem_ready = v.rdy;
      br_taken  = v.bt;
      @(negedge clk);
      chk(v.name, v.exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl.push_back(mk(I_ADDI, 1, 0, O_ZERO, "boot"));
      tbl.push_back(mk(I_ADDI, 1, 0, O_FETCH, "addi_fetch"));
      tbl.push_back(mk(I_ADDI, 1, 0, O_ZERO, "addi_decode"));
      tbl.push_back(mk(I_ADDI, 1, 1, 16'b0000_0000_0101_0000, "addi_exec"));
      tbl.push_back(mk(I_ADDI, 1, 0, O_WBALU, "addi_wb"));
      tbl.push_back(mk(I_LW, 1, 0, O_FETCH, "lw_fetch"));
      tbl.push_back(mk(I_LW, 1, 0, O_ZERO, "lw_decode"));
      tbl.push_back(mk(I_LW, 1, 0, O_AGEN, "lw_exec"));
      tbl.push_back(mk(I_LW, 0, 0, O_LDMEM, "lw_mem_wait1"));
      tbl.push_back(mk(I_LW, 0, 0, O_LDMEM, "lw_mem_wait2"));
      tbl.push_back(mk(I_LW, 0, 0, O_LDMEM, "lw_mem_wait3"));
      tbl.push_back(mk(I_LW, 1, 0, O_LDMEM, "lw_mem_done"));
      tbl.push_back(mk(I_LW, 1, 0, 16'b0000_1100_0000_0110, "lw_wb"));
      tbl.push_back(mk(I_BEQ, 1, 0, O_FETCH, "beq_t_fetch"));
      tbl.push_back(mk(I_BEQ, 1, 0, O_ZERO, "beq_t_decode"));
      tbl.push_back(mk(I_BEQ, 1, 1, 16'b0000_0101_1100_0010, "beq_t_exec"));
      tbl.push_back(mk(I_BEQ, 1, 0, O_FETCH, "beq_n_fetch"));
      tbl.push_back(mk(I_BEQ, 1, 0, O_ZERO, "beq_n_decode"));
      tbl.push_back(mk(I_BEQ, 1, 0, 16'b0000_0100_1100_0010, "beq_n_exec"));
      tbl.push_back(mk(I_JALR, 1, 0, O_FETCH, "jalr_fetch"));
      tbl.push_back(mk(I_JALR, 1, 0, O_ZERO, "jalr_decode"));
      tbl.push_back(mk(I_JALR, 1, 0, O_AGEN, "jalr_exec"));
      tbl.push_back(mk(I_JALR, 1, 0, 16'b0000_1110_0000_1010, "jalr_wb"));
      tbl.push_back(mk(I_SW, 1, 0, O_FETCH, "sw_fetch"));
      tbl.push_back(mk(I_SW, 1, 0, O_ZERO, "sw_decode"));
      tbl.push_back(mk(I_SW, 1, 0, O_AGEN, "sw_exec"));
      tbl.push_back(mk(I_SW, 1, 0, 16'b0110_0100_0100_0010, "sw_mem"));
      tbl.push_back(mk(I_LUI, 0, 0, O_FWAIT, "lui_fetch_wait"));
      tbl.push_back(mk(I_LUI, 1, 0, O_FETCH, "lui_fetch"));
      tbl.push_back(mk(I_LUI, 1, 0, O_ZERO, "lui_decode"));
      tbl.push_back(mk(I_LUI, 1, 0, 16'b0000_0000_0110_0000, "lui_exec"));
      tbl.push_back(mk(I_LUI, 1, 0, O_WBALU, "lui_wb"));
      tbl.push_back(mk(I_JAL, 1, 0, O_FETCH, "jal_fetch"));
      tbl.push_back(mk(I_JAL, 1, 0, O_ZERO, "jal_decode"));
      tbl.push_back(mk(I_JAL, 1, 0, 16'b0000_0000_1100_0000, "jal_exec"));
      tbl.push_back(mk(I_JAL, 1, 0, 16'b0000_1101_0000_1010, "jal_wb"));
      tbl.push_back(mk(I_AUIPC, 1, 0, O_FETCH, "auipc_fetch"));
      tbl.push_back(mk(I_AUIPC, 1, 0, O_ZERO, "auipc_decode"));
      tbl.push_back(mk(I_AUIPC, 1, 0, 16'b0000_0000_1100_0000, "auipc_exec"));
      tbl.push_back(mk(I_AUIPC, 1, 0, O_WBALU, "auipc_wb"));
      tbl.push_back(mk(I_ADD, 1, 0, O_FETCH, "add_fetch"));
      tbl.push_back(mk(I_ADD, 1, 0, O_ZERO, "add_decode"));
      tbl.push_back(mk(I_ADD, 1, 0, 16'b0000_0000_0001_0000, "add_exec"));
      tbl.push_back(mk(I_ADD, 1, 0, O_WBALU, "add_wb"));
      tbl.push_back(mk(I_FENCE, 1, 0, O_FETCH, "fence_fetch"));
      tbl.push_back(mk(I_FENCE, 1, 0, O_ZERO, "fence_decode"));
      tbl.push_back(mk(I_FENCE, 1, 0, 16'b0000_0100_0000_0010, "fence_exec"));
      tbl.push_back(mk(I_BAD, 1, 0, O_FETCH, "bad_fetch"));
      tbl.push_back(mk(I_BAD, 1, 0, O_ZERO, "bad_decode"));
      for (int k = 0; k < 10; k++) begin
         tbl.push_back(mk(I_BAD, 1, 0, O_TRAP, "trap_hold"));
      end

      rst_n     = 1'b0;
      inst      = I_ADDI;
      mem_ready = 1'b0;
      br_taken  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", O_ZERO);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i]);
      end

      // Reset is the only way out of TRAP
      rst_n = 1'b0;
      #1;
      chk("trap_reset_clear", O_ZERO);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(I_ADDI, 0, 0, O_ZERO, "boot_after_trap"));
      step(mk(I_ADDI, 0, 0, O_FWAIT, "fetch_wait1"));
      step(mk(I_ADDI, 0, 0, O_FWAIT, "fetch_wait2"));

      // Asynchronous reset while FETCH is still waiting
      rst_n = 1'b0;
      #1;
      chk("reset_mid_fetch", O_ZERO);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(I_LW, 1, 0, O_ZERO, "boot_after_fetch_rst"));
      step(mk(I_LW, 1, 0, O_FETCH, "first_fetch"));
      step(mk(I_LW, 1, 0, O_ZERO, "lw2_decode"));
      step(mk(I_LW, 1, 0, O_AGEN, "lw2_exec"));
      step(mk(I_LW, 0, 0, O_LDMEM, "lw2_mem_wait"));

      // Asynchronous reset while MEM is waiting
      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_mem", O_ZERO);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(I_LW, 1, 0, O_ZERO, "boot_after_mem_rst"));
      step(mk(I_LW, 1, 0, O_FETCH, "fetch_after_mem_rst"));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
